lcd_id_reader: RTL and testbench

//  Reads the RGB-LCD panel strap pins (M2,M1,M0) after reset and produces the
//  LCD ID code consumed by the LCD pixel-clock divider and the timing generator.

---
 rtl/lcd_id_reader.sv | 187 ++++++++++++++++++
 tb/tb_lcd_id_reader.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/lcd_id_reader.sv
// Reads the LCD panel strap pins from the shared RGB bus after reset, debounces
// them across several samples and publishes the decoded panel ID.
module lcd_id_reader #(
  parameter int SETTLE_CYC = 1000,
  parameter int SAMPLE_GAP = 100,
  parameter int N_SAMPLES  = 4,
  parameter int MAX_RETRY  = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [23:0] lcd_rgb_i,
  input  logic        rescan,
  output logic        rgb_oe,
  output logic [15:0] id_lcd,
  output logic        id_valid,
  output logic        id_err,
  output logic        busy
);

  localparam int SETTLE_W = $clog2(SETTLE_CYC) + 1;
  localparam int GAP_W    = $clog2(SAMPLE_GAP) + 1;
  localparam int MATCH_W  = $clog2(N_SAMPLES) + 1;
  localparam int RETRY_W  = $clog2(MAX_RETRY) + 1;

  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYC - 1);
  localparam logic [GAP_W-1:0]    GAP_LAST    = GAP_W'(SAMPLE_GAP - 1);
  localparam logic [MATCH_W-1:0]  MATCH_LAST  = MATCH_W'(N_SAMPLES - 1);
  localparam logic [RETRY_W-1:0]  RETRY_MAX   = RETRY_W'(MAX_RETRY);

  typedef enum logic [2:0] {IDLE, SETTLE, SAMPLE, DECODE, DONE} state_e;

  state_e              state_q, state_d;
  logic [2:0]          sync1_q, sync2_q;
  logic [2:0]          ref_q, ref_d;
  logic [SETTLE_W-1:0] settle_cnt_q, settle_cnt_d;
  logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
  logic [MATCH_W-1:0]  match_cnt_q, match_cnt_d;
  logic [RETRY_W-1:0]  retry_cnt_q, retry_cnt_d;
  logic                fail;
  logic                code_ok;
  logic [15:0]         code;

  logic        rgb_oe_q, rgb_oe_d;
  logic [15:0] id_lcd_q, id_lcd_d;
  logic        id_valid_q, id_valid_d;
  logic        id_err_q, id_err_d;
  logic        busy_q, busy_d;

  // NOTE: asynchronous active-low reset on every flop, and sequential state is
  // only ever written with non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      state_q      <= IDLE;
      ref_q        <= '0;
      settle_cnt_q <= '0;
      gap_cnt_q    <= '0;
      match_cnt_q  <= '0;
      retry_cnt_q  <= '0;
    end else begin
      sync1_q      <= {lcd_rgb_i[23], lcd_rgb_i[15], lcd_rgb_i[7]};
      sync2_q      <= sync1_q;
      state_q      <= state_d;
      ref_q        <= ref_d;
      settle_cnt_q <= settle_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      match_cnt_q  <= match_cnt_d;
      retry_cnt_q  <= retry_cnt_d;
    end
  end

  always_comb begin
    code_ok = 1'b1;
    code    = 16'd0;
    case (ref_q)
      3'b000:  code = 16'd0;
      3'b001:  code = 16'd1;
      3'b010:  code = 16'd2;
      3'b100:  code = 16'd4;
      3'b101:  code = 16'd5;
      default: code_ok = 1'b0;
    endcase
  end

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d      = state_q;
    ref_d        = ref_q;
    settle_cnt_d = settle_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    match_cnt_d  = match_cnt_q;
    retry_cnt_d  = retry_cnt_q;
    fail         = 1'b0;
    case (state_q)
      IDLE: begin
        state_d      = SETTLE;
        settle_cnt_d = '0;
        retry_cnt_d  = '0;
      end
      SETTLE: begin
        if (settle_cnt_q == SETTLE_LAST) begin
          state_d      = SAMPLE;
          settle_cnt_d = '0;
          gap_cnt_d    = '0;
          match_cnt_d  = '0;
        end else begin
          settle_cnt_d = settle_cnt_q + SETTLE_W'(1);
        end
      end
      SAMPLE: begin
        gap_cnt_d = (gap_cnt_q == GAP_LAST) ? '0 : gap_cnt_q + GAP_W'(1);
        if (gap_cnt_q == '0) begin
          // First sample of a scan becomes the reference the rest must match.
          if (match_cnt_q == '0) begin
            ref_d       = sync2_q;
            match_cnt_d = MATCH_W'(1);
          end else if (sync2_q == ref_q) begin
            if (match_cnt_q == MATCH_LAST) state_d = DECODE;
            else match_cnt_d = match_cnt_q + MATCH_W'(1);
          end else begin
            fail = 1'b1;
          end
        end
      end
      DECODE: begin
        if (code_ok) state_d = DONE;
        else         fail    = 1'b1;
      end
      DONE: begin
        if (rescan) begin
          state_d      = SETTLE;
          settle_cnt_d = '0;
          retry_cnt_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (fail) begin
      settle_cnt_d = '0;
      if (retry_cnt_q < RETRY_MAX) begin
        retry_cnt_d = retry_cnt_q + RETRY_W'(1);
        state_d     = SETTLE;
      end else begin
        state_d = DONE;
      end
    end
  end

  // Outputs are computed from the next state so they register on the same edge.
  always_comb begin
    rgb_oe_d   = (state_d == DONE);
    id_valid_d = (state_d == DONE);
    busy_d     = (state_d == SETTLE) || (state_d == SAMPLE) || (state_d == DECODE);
    id_lcd_d   = id_lcd_q;
    id_err_d   = id_err_q;
    if (state_q != DONE && state_d == DONE) begin
      id_lcd_d = fail ? 16'd0 : code;
      id_err_d = fail;
    end
    if (state_d == SETTLE && (state_q == IDLE || state_q == DONE)) id_err_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_oe_q   <= 1'b0;
      id_lcd_q   <= 16'd0;
      id_valid_q <= 1'b0;
      id_err_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      rgb_oe_q   <= rgb_oe_d;
      id_lcd_q   <= id_lcd_d;
      id_valid_q <= id_valid_d;
      id_err_q   <= id_err_d;
      busy_q     <= busy_d;
    end
  end

  assign rgb_oe   = rgb_oe_q;
  assign id_lcd   = id_lcd_q;
  assign id_valid = id_valid_q;
  assign id_err   = id_err_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_lcd_id_reader.sv
// Directed bench for lcd_id_reader: cycle-exact completion times and output
// values for stable, glitching, unknown, rescan and mid-scan reset scenarios.
module tb_lcd_id_reader;

  logic        clk;
  logic        rst_n;
  logic [23:0] lcd_rgb_i;
  logic        rescan;
  logic        rgb_oe;
  logic [15:0] id_lcd;
  logic        id_valid;
  logic        id_err;
  logic        busy;

  int total_cnt = 0;
  int pass_cnt  = 0;
  int n;

  lcd_id_reader dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .lcd_rgb_i(lcd_rgb_i),
    .rescan   (rescan),
    .rgb_oe   (rgb_oe),
    .id_lcd   (id_lcd),
    .id_valid (id_valid),
    .id_err   (id_err),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Non-strap bits are held high so a wrong bit index shows up as a wrong code.
  task automatic set_straps(input logic [2:0] s);
    logic [23:0] v;
    v     = 24'h7F7F7F;
    v[23] = s[2];
    v[15] = s[1];
    v[7]  = s[0];
    lcd_rgb_i = v;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Returns the number of rising edges until id_valid is seen high (bounded).
  task automatic wait_valid(input int max, output int cycles);
    cycles = 0;
    while (cycles < max) begin
      @(posedge clk);
      cycles++;
      #1;
      if (id_valid) break;
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    rescan    = 1'b0;
    set_straps(3'b001);
    #23;
    check("reset_rgb_oe",   32'(rgb_oe),   32'd0);
    check("reset_id_lcd",   32'(id_lcd),   32'd0);
    check("reset_id_valid", 32'(id_valid), 32'd0);
    check("reset_id_err",   32'(id_err),   32'd0);
    check("reset_busy",     32'(busy),     32'd0);

    // T1: straps 001 stable
    release_reset();
    @(posedge clk); #1;
    check("t1_busy_after_start", 32'(busy),   32'd1);
    check("t1_oe_released",      32'(rgb_oe), 32'd0);
    wait_valid(6000, n);
    check("t1_latency", 32'(1 + n), 32'd1303);
    check("t1_id_lcd",  32'(id_lcd), 32'd1);
    check("t1_id_err",  32'(id_err), 32'd0);
    check("t1_rgb_oe",  32'(rgb_oe), 32'd1);
    check("t1_busy",    32'(busy),   32'd0);

    // T2: straps 101 with a glitch to 100 at the third sample
    rst_n = 1'b0;
    set_straps(3'b101);
    #20;
    release_reset();
    repeat (1199) @(posedge clk);
    @(negedge clk);
    set_straps(3'b100);
    repeat (3) @(posedge clk);
    @(negedge clk);
    set_straps(3'b101);
    check("t2_busy_after_glitch", 32'(busy), 32'd1);
    wait_valid(6000, n);
    check("t2_latency", 32'(1202 + n), 32'd2504);
    check("t2_id_lcd",  32'(id_lcd), 32'd5);
    check("t2_id_err",  32'(id_err), 32'd0);

    // T3: unknown code 111 forever
    rst_n = 1'b0;
    set_straps(3'b111);
    #20;
    release_reset();
    wait_valid(8000, n);
    check("t3_latency",  32'(n),        32'd5209);
    check("t3_id_err",   32'(id_err),   32'd1);
    check("t3_id_lcd",   32'(id_lcd),   32'd0);
    check("t3_id_valid", 32'(id_valid), 32'd1);
    check("t3_rgb_oe",   32'(rgb_oe),   32'd1);

    // T4: ID 2, then rescan with straps 100
    rst_n = 1'b0;
    set_straps(3'b010);
    #20;
    release_reset();
    wait_valid(6000, n);
    check("t4_first_latency", 32'(n),      32'd1303);
    check("t4_first_id_lcd",  32'(id_lcd), 32'd2);
    @(negedge clk);
    set_straps(3'b100);
    rescan = 1'b1;
    @(posedge clk); #1;
    check("t4_valid_drops", 32'(id_valid), 32'd0);
    check("t4_oe_released", 32'(rgb_oe),   32'd0);
    check("t4_busy",        32'(busy),     32'd1);
    check("t4_id_held",     32'(id_lcd),   32'd2);
    @(negedge clk);
    rescan = 1'b0;
    wait_valid(6000, n);
    check("t4_rescan_latency", 32'(1 + n), 32'd1303);
    check("t4_final_id_lcd",   32'(id_lcd), 32'd4);
    check("t4_final_id_err",   32'(id_err), 32'd0);

    // T6: rst_n asserted during SAMPLE of a rescan
    @(negedge clk);
    set_straps(3'b001);
    rescan = 1'b1;
    @(negedge clk);
    rescan = 1'b0;
    repeat (1100) @(posedge clk);
    #2;
    check("t6_busy_before_reset", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t6_busy_async",   32'(busy),     32'd0);
    check("t6_rgb_oe_async", 32'(rgb_oe),   32'd0);
    check("t6_id_lcd_async", 32'(id_lcd),   32'd0);
    check("t6_valid_async",  32'(id_valid), 32'd0);
    check("t6_err_async",    32'(id_err),   32'd0);

    // T5 (continues T6): rescan pulse during SETTLE is ignored
    release_reset();
    repeat (500) @(posedge clk);
    @(negedge clk);
    rescan = 1'b1;
    @(negedge clk);
    rescan = 1'b0;
    check("t5_busy_after_pulse", 32'(busy), 32'd1);
    wait_valid(6000, n);
    check("t5_latency", 32'(501 + n), 32'd1303);
    check("t5_id_lcd",  32'(id_lcd),  32'd1);
    check("t5_rgb_oe",  32'(rgb_oe),  32'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
